// File: rtl/dm_resp.sv
// Data-memory responder: one CPU load/store at a time, WAIT_CYC wait states, byte/half/word access
// on a word-organised RAM. Define DM_PERF_CNT_EN to add rd_cnt/wr_cnt/err_cnt counters.
module dm_resp #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ctrl,
  output logic        resp_done,
  output logic [31:0] resp_rdata,
  output logic        resp_err
`ifdef DM_PERF_CNT_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [2:0] CtrlWord  = 3'b000;
  localparam logic [2:0] CtrlHalfS = 3'b001;
  localparam logic [2:0] CtrlHalfU = 3'b010;
  localparam logic [2:0] CtrlByteS = 3'b011;
  localparam logic [2:0] CtrlByteU = 3'b100;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        ctrl_q;

  logic [31:0]       mem [Depth];

  logic [ADDR_W-1:0] widx;
  logic [1:0]        lane;
  logic              acc_err;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;
  logic [3:0]        wr_mask;
  logic [31:0]       wr_data;
  logic              do_write;
  logic              accept;
  logic              in_resp;

  // Upper address bits alias onto the RAM and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];

  assign req_ready = (state_q == StIdle);
  assign accept    = req_ready && req_valid;
  assign in_resp   = (state_q == StResp);
  assign widx      = addr_q[ADDR_W+1:2];
  assign lane      = addr_q[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StWait;
          cnt_d   = 4'(WAIT_CYC);
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    case (ctrl_q)
      CtrlWord:             acc_err = (lane != 2'b00);
      CtrlHalfS, CtrlHalfU: acc_err = lane[0];
      CtrlByteS, CtrlByteU: acc_err = 1'b0;
      default:              acc_err = 1'b1;
    endcase
  end

  assign rd_word = mem[widx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (ctrl_q)
      CtrlWord:  load_data = rd_word;
      CtrlHalfS: load_data = {{16{rd_half[15]}}, rd_half};
      CtrlHalfU: load_data = {16'h0000, rd_half};
      CtrlByteS: load_data = {{24{rd_byte[7]}}, rd_byte};
      CtrlByteU: load_data = {24'h000000, rd_byte};
      default:   load_data = 32'h0;
    endcase
  end

  // Store data is replicated across lanes so the byte mask alone picks the target lane(s).
  always_comb begin
    case (ctrl_q)
      CtrlHalfS, CtrlHalfU: begin
        wr_mask = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      CtrlByteS, CtrlByteU: begin
        wr_mask = 4'b0001 << lane;
        wr_data = {4{wdata_q[7:0]}};
      end
      default: begin
        wr_mask = 4'b1111;
        wr_data = wdata_q;
      end
    endcase
  end

  assign do_write = in_resp && we_q && !acc_err;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) begin
          mem[widx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      ctrl_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr[ADDR_W+1:0];
        wdata_q <= req_wdata;
        ctrl_q  <= req_ctrl;
      end
    end
  end

  // Response registers update on the edge that leaves RESP, so done lines up with the
  // first IDLE cycle and rdata holds its value afterwards.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_done  <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      resp_done <= in_resp;
      if (in_resp) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_err || we_q) ? 32'h0 : load_data;
      end
    end
  end

`ifdef DM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_cnt  <= 32'h0;
      wr_cnt  <= 32'h0;
      err_cnt <= 16'h0;
    end else if (in_resp) begin
      if (acc_err) begin
        err_cnt <= err_cnt + 16'd1;
      end else if (we_q) begin
        wr_cnt <= wr_cnt + 32'd1;
      end else begin
        rd_cnt <= rd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_resp.sv
// Scoreboard bench for dm_resp: stimulus pushes expected responses, a negedge monitor pops and
// compares on every resp_done, including acceptance-to-done latency and req_ready while busy.
module tb_dm_resp;

  localparam int unsigned AddrW   = 7;
  localparam int unsigned WaitCyc = 2;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_ctrl;
  logic        resp_done;
  logic [31:0] resp_rdata;
  logic        resp_err;
`ifdef DM_PERF_CNT_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic [15:0] err_cnt;
`endif

  dm_resp #(
    .ADDR_W  (AddrW),
    .WAIT_CYC(WaitCyc)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ctrl  (req_ctrl),
    .resp_done (resp_done),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
`ifdef DM_PERF_CNT_EN
    ,
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc;
  int   n_checks;
  int   n_errors;
  logic ready_bad;
  int   m_rd, m_wr, m_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one pop per done pulse; also flags req_ready seen high while a request is pending.
  always @(negedge clk) begin
    if (rstn) begin
      if (resp_done) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got resp_done=1 expected no pending response");
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          check("latency", 32'(cyc - a), 32'(WaitCyc + 2));
          check("ready_low_busy", {31'b0, ready_bad}, 32'd0);
          ready_bad = 1'b0;
        end
      end else if (acc_q.size() != 0 && req_ready) begin
        ready_bad = 1'b1;
      end
    end
  end

  // Issue a request; with n > 1 req_valid is held so the same request is accepted n times.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] ctrl, input logic [31:0] exp_rd, input logic exp_e,
                       input int n);
    int acc;
    int budget;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{rdata: exp_rd, err: exp_e});
      if (exp_e) m_err++;
      else if (we) m_wr++;
      else m_rd++;
    end
    @(posedge clk);
    #1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_ctrl  = ctrl;
    req_valid = 1'b1;
    acc       = 0;
    budget    = 0;
    while (acc < n && budget < 100) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        acc++;
      end
      budget++;
    end
    req_valid = 1'b0;
    if (acc < n) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got %0d acceptances expected %0d", acc, n);
    end
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got %0d responses pending expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc       = 0;
    n_checks  = 0;
    n_errors  = 0;
    ready_bad = 1'b0;
    m_rd      = 0;
    m_wr      = 0;
    m_err     = 0;
    rstn      = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_ctrl  = 3'b000;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_done", {31'b0, resp_done}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    rstn = 1'b1;

    // Word store/load, then byte store over it.
    issue(1'b1, 32'h10, 32'h1234_5678, 3'b000, 32'h0, 1'b0, 1);
    issue(1'b0, 32'h10, 32'h0, 3'b000, 32'h1234_5678, 1'b0, 1);
    issue(1'b1, 32'h11, 32'h0000_00AB, 3'b011, 32'h0, 1'b0, 1);
    issue(1'b0, 32'h10, 32'h0, 3'b000, 32'h1234_AB78, 1'b0, 1);
    issue(1'b0, 32'h11, 32'h0, 3'b011, 32'hFFFF_FFAB, 1'b0, 1);
    issue(1'b0, 32'h11, 32'h0, 3'b100, 32'h0000_00AB, 1'b0, 1);

    // Half store into the upper lanes of a known word.
    issue(1'b1, 32'h20, 32'h5A5A_5A5A, 3'b000, 32'h0, 1'b0, 1);
    issue(1'b1, 32'h22, 32'h0000_8001, 3'b001, 32'h0, 1'b0, 1);
    issue(1'b0, 32'h22, 32'h0, 3'b001, 32'hFFFF_8001, 1'b0, 1);
    issue(1'b0, 32'h22, 32'h0, 3'b010, 32'h0000_8001, 1'b0, 1);
    issue(1'b0, 32'h20, 32'h0, 3'b010, 32'h0000_5A5A, 1'b0, 1);
    issue(1'b0, 32'h20, 32'h0, 3'b000, 32'h8001_5A5A, 1'b0, 1);

    // Misaligned and illegal requests.
    issue(1'b1, 32'h14, 32'h1122_3344, 3'b000, 32'h0, 1'b0, 1);
    issue(1'b0, 32'h13, 32'h0, 3'b000, 32'h0, 1'b1, 1);
    issue(1'b1, 32'h15, 32'h0000_FFFF, 3'b001, 32'h0, 1'b1, 1);
    issue(1'b0, 32'h14, 32'h0, 3'b000, 32'h1122_3344, 1'b0, 1);
    issue(1'b0, 32'h10, 32'h0, 3'b111, 32'h0, 1'b1, 1);

    // Reset during WAIT of a store aborts it.
    issue(1'b1, 32'h40, 32'hCAFE_F00D, 3'b000, 32'h0, 1'b0, 1);
    issue(1'b0, 32'h40, 32'h0, 3'b000, 32'hCAFE_F00D, 1'b0, 1);
    @(posedge clk);
    #1;
    req_we    = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'hDEAD_BEEF;
    req_ctrl  = 3'b000;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("wait_ready_low", {31'b0, req_ready}, 32'd0);
    rstn = 1'b0;
    #1;
    check("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst_resp_done", {31'b0, resp_done}, 32'd0);
    check("mid_rst_resp_rdata", resp_rdata, 32'h0);
    check("mid_rst_resp_err", {31'b0, resp_err}, 32'd0);
    m_rd  = 0;
    m_wr  = 0;
    m_err = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    check("post_rst_no_done", {31'b0, resp_done}, 32'd0);
    issue(1'b0, 32'h40, 32'h0, 3'b000, 32'hCAFE_F00D, 1'b0, 1);

    // Held req_valid: accepted a second time only after returning to IDLE.
    issue(1'b0, 32'h10, 32'h0, 3'b000, 32'h1234_AB78, 1'b0, 2);

    // Address wrap-around: 0x200 aliases word 0.
    issue(1'b1, 32'h200, 32'h0BAD_C0DE, 3'b000, 32'h0, 1'b0, 1);
    issue(1'b0, 32'h000, 32'h0, 3'b000, 32'h0BAD_C0DE, 1'b0, 1);
    issue(1'b0, 32'h003, 32'h0, 3'b011, 32'h0000_000B, 1'b0, 1);

`ifdef DM_PERF_CNT_EN
    repeat (2) @(negedge clk);
    check("rd_cnt", rd_cnt, 32'(m_rd));
    check("wr_cnt", wr_cnt, 32'(m_wr));
    check("err_cnt", {16'h0, err_cnt}, 32'(m_err));
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
